// File: rtl/baud_tick_scheduler.sv
// Shared UART baud divider: generates the rx oversample strobe and the tx bit
// strobe from one counter chain, and owns the runtime divisor register.
// A new divisor is held as pending and applied only on a tx bit boundary.
module baud_tick_scheduler #(
  parameter int unsigned CLK          = 50000000,
  parameter int unsigned DEFAULT_BAUD = 9600,
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DIV_WIDTH    = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 rx_sync,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_data,
  output logic                 rx_tick,
  output logic                 tx_tick,
  output logic                 div_ack,
  output logic                 div_err,
  output logic [DIV_WIDTH-1:0] divisor,
  output logic                 pending
);

  localparam int unsigned DEFAULT_DIV = CLK / (DEFAULT_BAUD * OVERSAMPLE);
  localparam int unsigned SUB_W       = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [DIV_WIDTH-1:0] DIV_RST  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN  = DIV_WIDTH'(2);
  localparam logic [SUB_W-1:0]     SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0]     SUB_ONE  = SUB_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [DIV_WIDTH-1:0] base_cnt, base_next;
  logic [SUB_W-1:0]     sub_cnt, sub_next;
  logic [DIV_WIDTH-1:0] pending_div, pending_div_next;
  logic [DIV_WIDTH-1:0] divisor_next;
  logic                 pending_next;
  logic                 rx_next, tx_next, ack_next, err_next;

  logic                 wr_ok_c;
  logic                 base_wrap_c;
  logic                 sub_wrap_c;

  // Request qualification and counter terminal-count detection
  always_comb begin
    wr_ok_c     = div_wr && (div_data >= DIV_MIN);
    base_wrap_c = (base_cnt == (divisor - DIV_ONE));
    sub_wrap_c  = (sub_cnt == SUB_LAST);
  end

  // Next-state, counter and strobe computation
  always_comb begin
    state_next       = state;
    base_next        = base_cnt;
    sub_next         = sub_cnt;
    divisor_next     = divisor;
    pending_next     = pending;
    pending_div_next = pending_div;
    rx_next          = 1'b0;
    tx_next          = 1'b0;
    ack_next         = 1'b0;
    err_next         = 1'b0;

    // Illegal divisors are rejected in every state
    if (div_wr && !wr_ok_c) begin
      err_next = 1'b1;
    end

    if (!enable) begin
      // Idle: counters parked at zero; a legal write takes effect at once
      // and supersedes anything still pending
      base_next = '0;
      sub_next  = '0;
      if (wr_ok_c) begin
        divisor_next = div_data;
        pending_next = 1'b0;
        ack_next     = 1'b1;
      end
    end else begin
      if (rx_sync) begin
        // Start-bit realignment wins over any strobe on this edge
        base_next = '0;
        sub_next  = '0;
      end else if (base_wrap_c) begin
        base_next = '0;
        rx_next   = 1'b1;
        if (sub_wrap_c) begin
          sub_next = '0;
          tx_next  = 1'b1;
          // Bit boundary: the only point where the rate may change
          if (state == PEND) begin
            divisor_next = pending_div;
            pending_next = 1'b0;
            ack_next     = 1'b1;
          end
        end else begin
          sub_next = sub_cnt + SUB_ONE;
        end
      end else begin
        base_next = base_cnt + DIV_ONE;
      end

      // A write on the apply edge becomes the next pending value
      if (wr_ok_c) begin
        pending_div_next = div_data;
        pending_next     = 1'b1;
      end
    end

    if (!enable) begin
      state_next = IDLE;
    end else if (pending_next) begin
      state_next = PEND;
    end else begin
      state_next = RUN;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      base_cnt    <= '0;
      sub_cnt     <= '0;
      divisor     <= DIV_RST;
      pending     <= 1'b0;
      pending_div <= DIV_RST;
      rx_tick     <= 1'b0;
      tx_tick     <= 1'b0;
      div_ack     <= 1'b0;
      div_err     <= 1'b0;
    end else begin
      state       <= state_next;
      base_cnt    <= base_next;
      sub_cnt     <= sub_next;
      divisor     <= divisor_next;
      pending     <= pending_next;
      pending_div <= pending_div_next;
      rx_tick     <= rx_next;
      tx_tick     <= tx_next;
      div_ack     <= ack_next;
      div_err     <= err_next;
    end
  end

endmodule

// File: tb/tb_baud_tick_scheduler.sv
// Directed bench for baud_tick_scheduler with a 4-clock default divisor.
module tb_baud_tick_scheduler;

  localparam int unsigned DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          rx_sync = 1'b0;
  logic          div_wr = 1'b0;
  logic [DW-1:0] div_data = '0;
  logic          rx_tick, tx_tick, div_ack, div_err, pending;
  logic [DW-1:0] divisor;

  int checks = 0;
  int failures = 0;

  baud_tick_scheduler #(
    .CLK(1600), .DEFAULT_BAUD(25), .OVERSAMPLE(16), .DIV_WIDTH(DW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx_sync(rx_sync),
    .div_wr(div_wr), .div_data(div_data), .rx_tick(rx_tick), .tx_tick(tx_tick),
    .div_ack(div_ack), .div_err(div_err), .divisor(divisor), .pending(pending)
  );

  always #5 clock = ~clock;

  // Edges until rx_tick is seen, sampled on the falling edge
  task automatic wait_rx(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rx_tick && n < 40);
  endtask

  // Edges until tx_tick, also counting rx strobes and acks along the way
  task automatic wait_tx(output int n, output int rxc, output int ackc);
    n = 0; rxc = 0; ackc = 0;
    do begin
      @(negedge clock);
      n++;
      if (rx_tick) rxc++;
      if (div_ack) ackc++;
    end while (!tx_tick && n < 300);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({rx_tick, tx_tick, div_ack, div_err, pending} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000", {rx_tick, tx_tick, div_ack, div_err, pending});
    end
    checks++;
    if (divisor !== 16'd4) begin
      failures++;
      $display("FAIL reset_divisor got=%0d want=4", divisor);
    end
  endtask

  task automatic test_run_rates;
    int n, rxc, ackc;
    reset = 1'b0; enable = 1'b1;
    wait_rx(n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL first_rx got=%0d want=4", n); end
    wait_rx(n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL rx_period got=%0d want=4", n); end
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 56 || rxc !== 14 || rx_tick !== 1'b1) begin
      failures++;
      $display("FAIL first_tx got=%0d/%0d/%b want=56/14/1", n, rxc, rx_tick);
    end
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 64 || rxc !== 16 || ackc !== 0) begin
      failures++;
      $display("FAIL tx_period got=%0d/%0d/%0d want=64/16/0", n, rxc, ackc);
    end
  endtask

  task automatic test_pending_apply;
    int n, rxc, ackc;
    repeat (3) wait_rx(n);
    div_wr = 1'b1; div_data = 16'd6;
    @(negedge clock);
    div_wr = 1'b0;
    checks++;
    if (pending !== 1'b1 || divisor !== 16'd4 || div_ack !== 1'b0) begin
      failures++;
      $display("FAIL pend_set got=%b/%0d/%b want=1/4/0", pending, divisor, div_ack);
    end
    wait_rx(n);
    checks++;
    if (n !== 3) begin failures++; $display("FAIL pend_rate_hold got=%0d want=3", n); end
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 48 || ackc !== 1 || div_ack !== 1'b1 || divisor !== 16'd6 || pending !== 1'b0) begin
      failures++;
      $display("FAIL apply got=%0d/%0d/%b/%0d/%b want=48/1/1/6/0", n, ackc, div_ack, divisor, pending);
    end
    wait_rx(n);
    checks++;
    if (n !== 6) begin failures++; $display("FAIL rx_period6 got=%0d want=6", n); end
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 90 || rxc !== 15) begin
      failures++;
      $display("FAIL tx_period6 got=%0d/%0d want=90/15", n, rxc);
    end
  endtask

  task automatic test_back_to_back;
    int n, rxc, ackc;
    div_wr = 1'b1; div_data = 16'd8;
    @(negedge clock);
    div_wr = 1'b0;
    checks++;
    if (pending !== 1'b1 || divisor !== 16'd6) begin
      failures++;
      $display("FAIL pend8 got=%b/%0d want=1/6", pending, divisor);
    end
    wait_rx(n);
    checks++;
    if (n !== 5) begin failures++; $display("FAIL rx_before_overwrite got=%0d want=5", n); end
    div_wr = 1'b1; div_data = 16'd5;
    @(negedge clock);
    div_wr = 1'b0;
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 89 || ackc !== 1 || divisor !== 16'd5 || div_ack !== 1'b1) begin
      failures++;
      $display("FAIL overwrite_apply got=%0d/%0d/%0d/%b want=89/1/5/1", n, ackc, divisor, div_ack);
    end
    wait_rx(n);
    checks++;
    if (n !== 5) begin failures++; $display("FAIL rx_period5 got=%0d want=5", n); end
    div_wr = 1'b1; div_data = 16'd4;
    @(negedge clock);
    div_wr = 1'b0;
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 74 || divisor !== 16'd4 || div_ack !== 1'b1) begin
      failures++;
      $display("FAIL restore4 got=%0d/%0d/%b want=74/4/1", n, divisor, div_ack);
    end
  endtask

  task automatic test_div_err;
    div_wr = 1'b1; div_data = 16'd1;
    @(negedge clock);
    div_wr = 1'b0;
    checks++;
    if (div_err !== 1'b1 || pending !== 1'b0 || divisor !== 16'd4 || div_ack !== 1'b0) begin
      failures++;
      $display("FAIL err_div1 got=%b/%b/%0d/%b want=1/0/4/0", div_err, pending, divisor, div_ack);
    end
    @(negedge clock);
    checks++;
    if (div_err !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%b want=0", div_err); end
    div_wr = 1'b1; div_data = 16'd0;
    @(negedge clock);
    div_wr = 1'b0;
    checks++;
    if (div_err !== 1'b1 || pending !== 1'b0 || divisor !== 16'd4) begin
      failures++;
      $display("FAIL err_div0 got=%b/%b/%0d want=1/0/4", div_err, pending, divisor);
    end
    @(negedge clock);
    checks++;
    if (div_err !== 1'b0 || rx_tick !== 1'b1) begin
      failures++;
      $display("FAIL err_rate_kept got=%b/%b want=0/1", div_err, rx_tick);
    end
  endtask

  task automatic test_rx_sync;
    int n, rxc, ackc;
    repeat (3) @(negedge clock);
    rx_sync = 1'b1;
    @(negedge clock);
    rx_sync = 1'b0;
    checks++;
    if (rx_tick !== 1'b0 || tx_tick !== 1'b0) begin
      failures++;
      $display("FAIL sync_suppress got=%b/%b want=0/0", rx_tick, tx_tick);
    end
    wait_rx(n);
    checks++;
    if (n !== 4) begin failures++; $display("FAIL sync_rx got=%0d want=4", n); end
    wait_tx(n, rxc, ackc);
    checks++;
    if (n !== 60 || rxc !== 15) begin
      failures++;
      $display("FAIL sync_tx got=%0d/%0d want=60/15", n, rxc);
    end
  endtask

  task automatic test_idle_and_reset;
    int n, strobes;
    enable = 1'b0; div_wr = 1'b1; div_data = 16'd7;
    @(negedge clock);
    div_wr = 1'b0;
    checks++;
    if (div_ack !== 1'b1 || divisor !== 16'd7 || pending !== 1'b0 || rx_tick !== 1'b0 || tx_tick !== 1'b0) begin
      failures++;
      $display("FAIL idle_apply got=%b/%0d/%b/%b/%b want=1/7/0/0/0", div_ack, divisor, pending, rx_tick, tx_tick);
    end
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rx_tick || tx_tick || div_ack) strobes++;
    end
    checks++;
    if (strobes !== 0) begin failures++; $display("FAIL idle_quiet got=%0d want=0", strobes); end
    enable = 1'b1; div_wr = 1'b1; div_data = 16'd9;
    @(negedge clock);
    div_wr = 1'b0;
    checks++;
    if (pending !== 1'b1 || divisor !== 16'd7) begin
      failures++;
      $display("FAIL run_pend9 got=%b/%0d want=1/7", pending, divisor);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (divisor !== 16'd4 || {pending, rx_tick, tx_tick, div_ack, div_err} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset got=%0d/%b want=4/00000", divisor, {pending, rx_tick, tx_tick, div_ack, div_err});
    end
    reset = 1'b0;
    wait_rx(n);
    checks++;
    if (n !== 4 || pending !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_rx got=%0d/%b want=4/0", n, pending);
    end
  endtask

  initial begin
    test_reset;
    test_run_rates;
    test_pending_apply;
    test_back_to_back;
    test_div_err;
    test_rx_sync;
    test_idle_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
